// File: rtl/mem_router.sv
// Address-decoding router from one host port to NUM_SLAVES slave channels, with a sticky error log.
// Define MEM_ROUTER_TIMEOUT_EN to enable the per-request wait timeout. Without it, a hit waits for slv_ready_i indefinitely.
module mem_router #(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000},
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         host_req_i,
    input  logic                         host_we_i,
    input  logic [3:0]                   host_be_i,
    input  logic [31:0]                  host_addr_i,
    input  logic [31:0]                  host_wdata_i,
    output logic                         host_gnt_o,
    output logic                         host_rvalid_o,
    output logic                         host_err_o,
    output logic [31:0]                  host_rdata_o,
    output logic [NUM_SLAVES-1:0]        slv_valid_o,
    input  logic [NUM_SLAVES-1:0]        slv_ready_i,
    output logic [31:0]                  slv_addr_o,
    output logic [31:0]                  slv_wdata_o,
    output logic [3:0]                   slv_wstrb_o,
    input  logic [NUM_SLAVES*32-1:0]     slv_rdata_i,
    output logic                         err_valid_o,
    output logic [31:0]                  err_addr_o,
    input  logic                         err_clear_i
);

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] selHot;
    logic                  miss;
    logic                  selReady;
    logic [31:0]           selRdata;
    logic                  timeout;
    logic                  grant;

    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  errValid_q, errValid_d;
    logic [31:0]           errAddr_q, errAddr_d;

    // Priority decode: the lowest-indexed matching window wins, so selHot is one-hot or zero.
    always_comb begin
        hit      = '0;
        selHot   = '0;
        miss     = 1'b1;
        selRdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((host_addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
            if (hit[i] && miss) begin
                selHot[i] = 1'b1;
                miss      = 1'b0;
            end
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (selHot[i]) begin
                selRdata = selRdata | slv_rdata_i[i*32 +: 32];
            end
        end
    end

    assign selReady = |(slv_ready_i & selHot);

`ifdef MEM_ROUTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] waitCnt_q, waitCnt_d;

    assign timeout = host_req_i && !miss && !selReady && (waitCnt_q == TIMEOUT_LAST);

    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!host_req_i || grant) begin
            waitCnt_d = '0;
        end else if (!miss && !selReady) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign grant       = host_req_i && (miss || selReady || timeout);
    assign host_gnt_o  = grant;
    assign slv_valid_o = (host_req_i && !timeout) ? selHot : '0;
    assign slv_addr_o  = host_addr_i;
    assign slv_wdata_o = host_wdata_i;
    assign slv_wstrb_o = host_we_i ? host_be_i : 4'b0000;

    // A new error captured in the same cycle as a clear takes priority over the clear.
    always_comb begin
        rvalid_d   = grant;
        err_d      = grant && (miss || timeout);
        rdata_d    = '0;
        errValid_d = errValid_q;
        errAddr_d  = errAddr_q;
        if (grant && !host_we_i && !miss && !timeout) begin
            rdata_d = selRdata;
        end
        if (err_d && (!errValid_q || err_clear_i)) begin
            errValid_d = 1'b1;
            errAddr_d  = host_addr_i;
        end else if (err_clear_i) begin
            errValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            errValid_q <= 1'b0;
            errAddr_q  <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            errValid_q <= errValid_d;
            errAddr_q  <= errAddr_d;
        end
    end

    assign host_rvalid_o = rvalid_q;
    assign host_err_o    = err_q;
    assign host_rdata_o  = rdata_q;
    assign err_valid_o   = errValid_q;
    assign err_addr_o    = errAddr_q;

endmodule
